acc_alu_seq: RTL and testbench

//  Parametrised, clocked successor of the accumulator ALU. Holds the accumulator and the
//  co/z/neg flags in registers. Executes single-cycle arithmetic/logic ops and multi-cycle

---
 rtl/acc_alu_seq.sv | 229 ++++++++++++++++++++++
 tb/tb_acc_alu_seq.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_alu_seq.sv
// acc_alu_seq: clocked accumulator ALU with registered acc/co/z/neg flags.
// Single-cycle arithmetic/logic ops, multi-cycle iterative shifts and an
// optional radix-2 shift-add multiplier, under a valid/ready/done handshake.
// Optional feature macro: ACC_ALU_MUL_EN (compiles in the MUL state/datapath).
module acc_alu_seq #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         op_valid,
  input  logic [3:0]   op,
  input  logic [W-1:0] in_a,
  input  logic         ci,
  output logic         ready,
  output logic         done,
  output logic [W-1:0] acc,
  output logic         co,
  output logic         z,
  output logic         neg
);

  localparam int unsigned SH_W = $clog2(W);
  // One extra bit so the counter can also hold W for the multiplier.
  localparam int unsigned CntW = SH_W + 1;

  localparam logic [3:0] OpAdd = 4'd0;
  localparam logic [3:0] OpSub = 4'd1;
  localparam logic [3:0] OpAnd = 4'd2;
  localparam logic [3:0] OpXor = 4'd3;
  localparam logic [3:0] OpNot = 4'd4;
  localparam logic [3:0] OpShl = 4'd5;
  localparam logic [3:0] OpShr = 4'd6;
  localparam logic [3:0] OpLda = 4'd7;
  localparam logic [3:0] OpClr = 4'd8;
`ifdef ACC_ALU_MUL_EN
  localparam logic [3:0] OpMul = 4'd9;
`endif

`ifdef ACC_ALU_MUL_EN
  typedef enum logic [1:0] {StIdle, StShift, StMul} state_t;
`else
  typedef enum logic [1:0] {StIdle, StShift} state_t;
`endif

  state_t            state_q, state_d;
  logic [W-1:0]      acc_q, acc_d;
  logic              co_q, co_d;
  logic              z_q, z_d;
  logic              neg_q, neg_d;
  logic              done_q, done_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              shl_q, shl_d;
  logic              set_flags;

`ifdef ACC_ALU_MUL_EN
  logic [2*W-1:0]    mcand_q, mcand_d;
  logic [W-1:0]      mplier_q, mplier_d;
  logic [2*W-1:0]    prod_q, prod_d;
`endif

  logic [W:0]        add_sum;
  logic [W:0]        sub_sum;
  logic [W-1:0]      shl_val;
  logic [W-1:0]      shr_val;
  logic [SH_W-1:0]   sh_n;

  // Arithmetic is done on W+1 bits so the carry falls out of the top bit.
  assign add_sum = {1'b0, acc_q} + {1'b0, in_a} + {{W{1'b0}}, ci};
  assign sub_sum = {1'b0, acc_q} + {1'b0, ~in_a} + {{W{1'b0}}, 1'b1};
  assign shl_val = {acc_q[W-2:0], 1'b0};
  assign shr_val = {1'b0, acc_q[W-1:1]};
  assign sh_n    = in_a[SH_W-1:0];

  // Next-state logic: op decode in IDLE, iteration in SHIFT/MUL.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    co_d      = co_q;
    z_d       = z_q;
    neg_d     = neg_q;
    done_d    = 1'b0;
    cnt_d     = cnt_q;
    shl_d     = shl_q;
    set_flags = 1'b0;
`ifdef ACC_ALU_MUL_EN
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    prod_d    = prod_q;
`endif
    case (state_q)
      StIdle: begin
        if (op_valid) begin
          done_d = 1'b1;
          case (op)
            OpAdd: begin
              acc_d     = add_sum[W-1:0];
              co_d      = add_sum[W];
              set_flags = 1'b1;
            end
            OpSub: begin
              acc_d     = sub_sum[W-1:0];
              co_d      = sub_sum[W];
              set_flags = 1'b1;
            end
            OpAnd: begin
              acc_d     = acc_q & in_a;
              co_d      = 1'b0;
              set_flags = 1'b1;
            end
            OpXor: begin
              acc_d     = acc_q ^ in_a;
              co_d      = 1'b0;
              set_flags = 1'b1;
            end
            OpNot: begin
              acc_d     = ~acc_q;
              co_d      = 1'b0;
              set_flags = 1'b1;
            end
            OpLda: begin
              acc_d     = in_a;
              co_d      = 1'b0;
              set_flags = 1'b1;
            end
            OpClr: begin
              acc_d = '0;
              co_d  = 1'b0;
              z_d   = 1'b0;
              neg_d = 1'b0;
            end
            OpShl, OpShr: begin
              if (sh_n == '0) begin
                co_d      = 1'b0;
                set_flags = 1'b1;
              end else begin
                done_d  = 1'b0;
                state_d = StShift;
                cnt_d   = {1'b0, sh_n};
                shl_d   = (op == OpShl);
              end
            end
`ifdef ACC_ALU_MUL_EN
            OpMul: begin
              done_d   = 1'b0;
              state_d  = StMul;
              mcand_d  = {{W{1'b0}}, acc_q};
              mplier_d = in_a;
              prod_d   = '0;
              cnt_d    = CntW'(W);
            end
`endif
            default: ;  // NOP: hold everything, done still pulses
          endcase
        end
      end
      StShift: begin
        acc_d = shl_q ? shl_val : shr_val;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          co_d      = shl_q ? acc_q[W-1] : acc_q[0];
          set_flags = 1'b1;
          done_d    = 1'b1;
          state_d   = StIdle;
        end
      end
`ifdef ACC_ALU_MUL_EN
      StMul: begin
        prod_d   = prod_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = {mcand_q[2*W-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[W-1:1]};
        cnt_d    = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          acc_d     = prod_d[W-1:0];
          co_d      = |prod_d[2*W-1:W];
          set_flags = 1'b1;
          done_d    = 1'b1;
          state_d   = StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
    if (set_flags) begin
      z_d   = (acc_d == '0);
      neg_d = acc_d[W-1];
    end
  end

  // State registers with synchronous reset; reset aborts any op in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      co_q     <= 1'b0;
      z_q      <= 1'b0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      shl_q    <= 1'b0;
`ifdef ACC_ALU_MUL_EN
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      co_q     <= co_d;
      z_q      <= z_d;
      neg_q    <= neg_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      shl_q    <= shl_d;
`ifdef ACC_ALU_MUL_EN
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
`endif
    end
  end

  assign ready = (state_q == StIdle);
  assign done  = done_q;
  assign acc   = acc_q;
  assign co    = co_q;
  assign z     = z_q;
  assign neg   = neg_q;

endmodule

// File: tb/tb_acc_alu_seq.sv
// tb_acc_alu_seq: table-driven directed vectors, hand-written reset and
// back-to-back sequences, then random ops checked against a behavioural model.
module tb_acc_alu_seq;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         op_valid;
  logic [3:0]   op;
  logic [W-1:0] in_a;
  logic         ci;
  logic         ready;
  logic         done;
  logic [W-1:0] acc;
  logic         co;
  logic         z;
  logic         neg;

  int n_chk;
  int n_err;

  // Reference state of the accumulator and flags.
  logic [7:0] m_acc;
  logic       m_co, m_z, m_neg;

  acc_alu_seq #(.W(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .op_valid (op_valid),
    .op       (op),
    .in_a     (in_a),
    .ci       (ci),
    .ready    (ready),
    .done     (done),
    .acc      (acc),
    .co       (co),
    .z        (z),
    .neg      (neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic       c;
    logic [7:0] e_acc;
    logic       e_co;
    logic       e_z;
    logic       e_neg;
    int         e_lat;
  } vec_t;

  vec_t vecs[23];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected result of one op from the arithmetic rules, starting at m_*.
  task automatic model_step(input logic [3:0] o, input logic [7:0] a, input logic c,
                            output logic [7:0] na, output logic nco, output logic nz,
                            output logic nneg, output int lat);
    int ac, ai, n, r, p;
    logic upd;
    ac  = int'(m_acc);
    ai  = int'(a);
    n   = ai % 8;
    r   = ac;
    nco = 1'b0;
    nz  = m_z;
    nneg = m_neg;
    lat = 1;
    upd = 1'b1;
    case (o)
      4'd0: begin p = ac + ai + int'(c); r = p % 256; nco = (p > 255); end
      4'd1: begin r = (ac - ai + 256) % 256; nco = (ac >= ai); end
      4'd2: r = ac & ai;
      4'd3: r = ac ^ ai;
      4'd4: r = 255 - ac;
      4'd5: begin
        r = (ac << n) % 256;
        nco = (n == 0) ? 1'b0 : 1'(((ac >> (8 - n)) & 1));
        lat = (n == 0) ? 1 : n + 1;
      end
      4'd6: begin
        r = ac >> n;
        nco = (n == 0) ? 1'b0 : 1'(((ac >> (n - 1)) & 1));
        lat = (n == 0) ? 1 : n + 1;
      end
      4'd7: r = ai;
      4'd8: begin r = 0; nz = 1'b0; nneg = 1'b0; upd = 1'b0; end
`ifdef ACC_ALU_MUL_EN
      4'd9: begin p = ac * ai; r = p % 256; nco = (p > 255); lat = 9; end
`endif
      default: begin nco = m_co; upd = 1'b0; end
    endcase
    na = 8'(r);
    if (upd) begin
      nz   = (r == 0);
      nneg = (r >= 128);
    end
  endtask

  // Issue one op at a negedge, wait for done with busy-cycle noise, compare.
  task automatic run_op(input logic [3:0] o, input logic [7:0] a, input logic c,
                        input logic [7:0] e_acc, input logic e_co, input logic e_z,
                        input logic e_neg, input int e_lat);
    int k;
    bit got;
    check("ready_idle", int'(ready), 1);
    op_valid = 1'b1;
    op       = o;
    in_a     = a;
    ci       = c;
    @(posedge clk);
    #1 op_valid = 1'b0;
    k   = 0;
    got = 1'b0;
    while (!got && k < 40) begin
      @(negedge clk);
      k++;
      if (done) begin
        got = 1'b1;
        op_valid = 1'b0;
      end else begin
        check("ready_busy", int'(ready), 0);
        // Requests while busy must be ignored.
        op_valid = 1'($urandom_range(0, 1));
        op       = 4'($urandom);
        in_a     = 8'($urandom);
        ci       = 1'($urandom);
      end
    end
    if (!got) begin
      check("done_timeout", 0, 1);
    end else begin
      check("latency", k, e_lat);
      check("acc", int'(acc), int'(e_acc));
      check("co", int'(co), int'(e_co));
      check("z", int'(z), int'(e_z));
      check("neg", int'(neg), int'(e_neg));
    end
    @(negedge clk);
    check("done_single_pulse", int'(done), 0);
    m_acc = e_acc;
    m_co  = e_co;
    m_z   = e_z;
    m_neg = e_neg;
  endtask

  logic [3:0] bb_op[4];
  logic [7:0] bb_a[4];
  logic [7:0] bb_exp[4];

  initial begin
    logic [3:0] ro;
    logic [7:0] ra, ea;
    logic       rc, eco, ez, eneg;
    int         el;

    n_chk = 0;
    n_err = 0;

    vecs[0]  = '{4'd7, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1};
    vecs[1]  = '{4'd0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1};
    vecs[2]  = '{4'd7, 8'h05, 1'b0, 8'h05, 1'b0, 1'b0, 1'b0, 1};
    vecs[3]  = '{4'd1, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b1, 1};
    vecs[4]  = '{4'd7, 8'h07, 1'b0, 8'h07, 1'b0, 1'b0, 1'b0, 1};
    vecs[5]  = '{4'd1, 8'h07, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1};
    vecs[6]  = '{4'd7, 8'h81, 1'b0, 8'h81, 1'b0, 1'b0, 1'b1, 1};
    vecs[7]  = '{4'd5, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0, 4};
    vecs[8]  = '{4'd7, 8'h81, 1'b0, 8'h81, 1'b0, 1'b0, 1'b1, 1};
    vecs[9]  = '{4'd6, 8'h01, 1'b0, 8'h40, 1'b1, 1'b0, 1'b0, 2};
    vecs[10] = '{4'd7, 8'h10, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 1};
`ifdef ACC_ALU_MUL_EN
    vecs[11] = '{4'd9, 8'h11, 1'b0, 8'h10, 1'b1, 1'b0, 1'b0, 9};
`else
    vecs[11] = '{4'd9, 8'h11, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 1};
`endif
    vecs[12] = '{4'd7, 8'h0F, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0, 1};
`ifdef ACC_ALU_MUL_EN
    vecs[13] = '{4'd9, 8'h03, 1'b0, 8'h2D, 1'b0, 1'b0, 1'b0, 9};
`else
    vecs[13] = '{4'd9, 8'h03, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0, 1};
`endif
    vecs[14] = '{4'd2, 8'h05, 1'b0, 8'h05, 1'b0, 1'b0, 1'b0, 1};
    vecs[15] = '{4'd12, 8'h5A, 1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 1};
    vecs[16] = '{4'd8, 8'h77, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1};
    vecs[17] = '{4'd15, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1};
    vecs[18] = '{4'd7, 8'h80, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 1};
    vecs[19] = '{4'd5, 8'h08, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 1};
    vecs[20] = '{4'd6, 8'h07, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 8};
    vecs[21] = '{4'd0, 8'hF0, 1'b0, 8'hF1, 1'b0, 1'b0, 1'b1, 1};
    vecs[22] = '{4'd0, 8'h0F, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1};

    bb_op  = '{4'd7, 4'd3, 4'd4, 4'd8};
    bb_a   = '{8'h3C, 8'hFF, 8'h00, 8'h00};
    bb_exp = '{8'h3C, 8'hC3, 8'h3C, 8'h00};

    reset    = 1'b1;
    op_valid = 1'b0;
    op       = 4'd0;
    in_a     = '0;
    ci       = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_acc", int'(acc), 0);
    check("rst_flags", int'({co, z, neg}), 0);
    check("rst_ready", int'(ready), 1);
    check("rst_done", int'(done), 0);
    m_acc = 8'h00;
    m_co  = 1'b0;
    m_z   = 1'b0;
    m_neg = 1'b0;

    for (int i = 0; i < 23; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].c, vecs[i].e_acc, vecs[i].e_co,
             vecs[i].e_z, vecs[i].e_neg, vecs[i].e_lat);
    end

    // Back-to-back single-cycle ops, one per cycle.
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        check("b2b_done", int'(done), 1);
        check("b2b_acc", int'(acc), int'(bb_exp[i-1]));
      end
      if (i < 4) begin
        check("b2b_ready", int'(ready), 1);
        op_valid = 1'b1;
        op       = bb_op[i];
        in_a     = bb_a[i];
        ci       = 1'b0;
      end else begin
        op_valid = 1'b0;
        check("b2b_z", int'(z), 0);
        check("b2b_neg", int'(neg), 0);
      end
      @(negedge clk);
    end
    check("b2b_done_end", int'(done), 0);
    m_acc = 8'h00;
    m_co  = 1'b0;
    m_z   = 1'b0;
    m_neg = 1'b0;

    // Reset held two cycles in the middle of SHL n=5 aborts the op.
    run_op(4'd7, 8'hA5, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1);
    op_valid = 1'b1;
    op       = 4'd5;
    in_a     = 8'h05;
    @(posedge clk);
    #1 op_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("shift_busy", int'(ready), 0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_done", int'(done), 0);
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_acc", int'(acc), 0);
    check("rst_mid_flags", int'({co, z, neg}), 0);
    check("rst_mid_ready", int'(ready), 1);
    for (int i = 0; i < 8; i++) begin
      check("rst_no_done", int'(done), 0);
      @(negedge clk);
    end
    m_acc = 8'h00;
    m_co  = 1'b0;
    m_z   = 1'b0;
    m_neg = 1'b0;

    // Random ops against the behavioural model.
    for (int i = 0; i < 300; i++) begin
      ro = 4'($urandom_range(0, 15));
      ra = 8'($urandom);
      rc = 1'($urandom);
      model_step(ro, ra, rc, ea, eco, ez, eneg, el);
      run_op(ro, ra, rc, ea, eco, ez, eneg, el);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
